// File: rtl/pbus_pkg.sv
// Shared definitions for the pbus burst source and its FIFO.
package pbus_pkg;

  localparam int unsigned PBUS_DW = 32;
  localparam int unsigned PBUS_LW = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STRB,
    ST_DONE
  } pbus_state_t;

endpackage

// File: rtl/pbus_fifo.sv
// Word FIFO feeding the burst source; first-word-fall-through read port.
module pbus_fifo
  import pbus_pkg::*;
#(
  parameter int unsigned DW    = PBUS_DW,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DW-1:0]            wdata,
  input  logic                     pop,
  output logic [DW-1:0]            rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Writes while full are dropped even if a pop frees a slot this cycle.
  always_comb begin
    full    = (count == CW'(DEPTH));
    empty   = (count == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    rdata   = mem[rd_ptr];
  end

  // Storage array: written at the write pointer on an accepted push.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally modulo DEPTH; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pbus_burst_src.sv
// Burst source: drains len words from a FIFO onto dout, one strobe per word.
module pbus_burst_src
  import pbus_pkg::*;
#(
  parameter int unsigned DW    = PBUS_DW,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned LW    = PBUS_LW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic          full,
  input  logic          start,
  input  logic [LW-1:0] len,
  output logic [DW-1:0] dout,
  output logic          strobe,
  output logic          busy,
  output logic          done,
  output logic          ovf
);

  pbus_state_t         state;
  pbus_state_t         state_nxt;
  logic [LW-1:0]       remaining;
  logic                pop;
  logic [DW-1:0]       fifo_rdata;
  logic                fifo_empty;
  // Occupancy is not needed here; full/empty cover every decision.
  logic [$clog2(DEPTH):0] unused_count;

  pbus_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_en),
    .wdata (wr_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (fifo_empty),
    .count (unused_count)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state: start only matters in IDLE, so starts while busy vanish.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (start) state_nxt = (len == '0) ? ST_DONE : ST_LOAD;
      ST_LOAD: if (!fifo_empty) state_nxt = ST_STRB;
      ST_STRB: state_nxt = (remaining != '0) ? ST_LOAD : ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Moore outputs plus the FIFO pop request.
  always_comb begin
    pop    = (state == ST_LOAD) && !fifo_empty;
    strobe = (state == ST_STRB);
    done   = (state == ST_DONE);
    busy   = (state != ST_IDLE);
  end

  // Datapath: dout updates only on LOAD->STRB, so it is settled before strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout      <= '0;
      remaining <= '0;
      ovf       <= 1'b0;
    end else begin
      if (state == ST_IDLE && start) remaining <= len;
      if (pop) begin
        dout      <= fifo_rdata;
        remaining <= remaining - LW'(1);
      end
      if (wr_en && full) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pbus_burst_src.sv
// Self-checking bench for pbus_burst_src.
module tb_pbus_burst_src;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned LW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          full;
  logic          start;
  logic [LW-1:0] len;
  logic [DW-1:0] dout;
  logic          strobe;
  logic          busy;
  logic          done;
  logic          ovf;

  pbus_burst_src #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .LW    (LW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .start   (start),
    .len     (len),
    .dout    (dout),
    .strobe  (strobe),
    .busy    (busy),
    .done    (done),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  int nerr = 0;
  int nchk = 0;
  int cyc  = 0;
  int ndone = 0;
  int last_strobe_cyc = -1;
  logic [DW-1:0] prev_dout = '0;
  logic [DW-1:0] cap [$];

  typedef struct {
    logic          wr;
    logic [DW-1:0] wd;
    logic          st;
    logic [LW-1:0] ln;
    logic          e_strobe;
    logic          e_busy;
    logic          e_done;
    logic          e_full;
    logic          e_ovf;
    logic [DW-1:0] e_dout;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample after the edge, record strobes/done, check protocol rules.
  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
    if (!rst && dout !== prev_dout) check("dout_changes_only_with_strobe", 64'(strobe), 64'd1);
    if (strobe) begin
      cap.push_back(dout);
      if (last_strobe_cyc >= 0) check("strobe_gap_ge_2", 64'(cyc - last_strobe_cyc >= 2), 64'd1);
      last_strobe_cyc = cyc;
    end
    if (done) ndone++;
    prev_dout = dout;
  endtask

  task automatic idle_inputs;
    rst = 1'b0; wr_en = 1'b0; wr_data = '0; start = 1'b0; len = '0;
  endtask

  task automatic do_reset;
    rst = 1'b1; wr_en = 1'b0; start = 1'b0;
    tick();
    idle_inputs();
    cap.delete();
    ndone = 0;
    last_strobe_cyc = -1;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    wr_en = 1'b1; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Reference: every accepted word comes out exactly once, in push order,
  // one per strobe, len strobes per burst, then a single done.
  task automatic run_burst(input int blen, input int prob);
    logic [DW-1:0] q [$];
    int pushed;
    int pre;
    int budget;
    int start_cyc;
    cap.delete(); ndone = 0; last_strobe_cyc = -1;
    pushed = 0;
    pre = $urandom_range(0, (blen < int'(DEPTH)) ? blen : int'(DEPTH));
    for (int i = 0; i < pre; i++) begin
      logic [DW-1:0] d;
      d = $urandom;
      q.push_back(d);
      push_word(d);
      pushed++;
    end
    start = 1'b1; len = LW'(blen);
    start_cyc = cyc + 1;
    budget = 20 * blen + 50;
    for (int c = 0; c < budget && ndone == 0; c++) begin
      if (pushed < blen && (pushed - cap.size()) < int'(DEPTH) &&
          $urandom_range(0, 99) < prob) begin
        logic [DW-1:0] d;
        d = $urandom;
        q.push_back(d);
        wr_en = 1'b1; wr_data = d;
        pushed++;
      end else begin
        wr_en = 1'b0;
      end
      tick();
      if (start && pre > 0) check("first_strobe_latency", 64'(busy), 64'd1);
      if (c == 1 && pre > 0) check("first_strobe_at_start_plus_2", 64'(strobe), 64'd1);
      start = 1'b0; wr_en = 1'b0;
    end
    check("burst_done_once", 64'(ndone), 64'd1);
    check("burst_word_count", 64'(cap.size()), 64'(blen));
    for (int i = 0; i < blen && i < cap.size(); i++)
      check($sformatf("burst_word[%0d]", i), 64'(cap[i]), 64'(q[i]));
    check("burst_no_ovf", 64'(ovf), 64'd0);
    tick();
    check("burst_idle_after", 64'(busy), 64'd0);
    if (start_cyc < 0) check("unreachable", 64'd0, 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();

    // Reset wins over start and wr_en in the same cycle.
    rst = 1'b1; wr_en = 1'b1; wr_data = 32'hDEAD; start = 1'b1; len = 8'd3;
    tick();
    check("reset_outputs", 64'({dout, strobe, busy, done, full, ovf}), 64'd0);
    idle_inputs();
    tick();
    check("reset_start_ignored", 64'(busy), 64'd0);
    check("reset_fifo_empty_no_full", 64'(full), 64'd0);
    cap.delete(); ndone = 0; last_strobe_cyc = -1;

    // Push 1..4 then a len=4 burst; a start during the burst is ignored.
    tbl[0]  = '{1'b1, 32'd1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
    tbl[1]  = '{1'b1, 32'd2, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
    tbl[2]  = '{1'b1, 32'd3, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
    tbl[3]  = '{1'b1, 32'd4, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
    tbl[4]  = '{1'b0, 32'd0, 1'b1, 8'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0};
    tbl[5]  = '{1'b0, 32'd0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd1};
    tbl[6]  = '{1'b0, 32'd0, 1'b1, 8'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd1};
    tbl[7]  = '{1'b0, 32'd0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd2};
    tbl[8]  = '{1'b0, 32'd0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd2};
    tbl[9]  = '{1'b0, 32'd0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd3};
    tbl[10] = '{1'b0, 32'd0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd3};
    tbl[11] = '{1'b0, 32'd0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd4};
    tbl[12] = '{1'b0, 32'd0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd4};
    tbl[13] = '{1'b0, 32'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd4};
    for (int i = 0; i < 14; i++) begin
      wr_en = tbl[i].wr; wr_data = tbl[i].wd; start = tbl[i].st; len = tbl[i].ln;
      tick();
      check($sformatf("vec[%0d] {strobe,busy,done,full,ovf,dout}", i),
            64'({strobe, busy, done, full, ovf, dout}),
            64'({tbl[i].e_strobe, tbl[i].e_busy, tbl[i].e_done, tbl[i].e_full,
                 tbl[i].e_ovf, tbl[i].e_dout}));
    end
    idle_inputs();

    // Empty-FIFO stall: words arrive late, burst waits, busy stays high.
    do_reset();
    start = 1'b1; len = 8'd3;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 60 && ndone == 0; k++) begin
      wr_en = (k == 5 || k == 9 || k == 10);
      wr_data = (k == 5) ? 32'hA : (k == 9) ? 32'hB : 32'hC;
      tick();
      check("stall_busy_held", 64'(busy), 64'd1);
    end
    wr_en = 1'b0;
    check("stall_done", 64'(ndone), 64'd1);
    check("stall_count", 64'(cap.size()), 64'd3);
    if (cap.size() == 3) check("stall_order", 64'({cap[0][3:0], cap[1][3:0], cap[2][3:0]}), 64'h0ABC);

    // Overflow: 9th push dropped, ovf sticky until reset.
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      push_word(DW'(i));
      if (i == 8) check("full_at_depth", 64'({full, ovf}), 64'b10);
    end
    check("ovf_after_9th", 64'({full, ovf}), 64'b11);
    start = 1'b1; len = 8'd8;
    tick();
    start = 1'b0;
    for (int c = 0; c < 60 && ndone == 0; c++) tick();
    check("ovf_burst_count", 64'(cap.size()), 64'd8);
    for (int i = 0; i < 8 && i < cap.size(); i++)
      check($sformatf("ovf_burst_word[%0d]", i), 64'(cap[i]), 64'(i + 1));
    check("ovf_sticky", 64'({full, ovf}), 64'b01);
    do_reset();
    check("ovf_cleared_by_rst", 64'(ovf), 64'd0);

    // len=0: straight to DONE, no strobe; start during DONE ignored.
    start = 1'b1; len = 8'd0;
    tick();
    check("len0_done", 64'({strobe, busy, done}), 64'b011);
    start = 1'b1; len = 8'd3;
    tick();
    start = 1'b0;
    check("len0_back_idle", 64'({strobe, busy, done}), 64'b000);
    for (int c = 0; c < 4; c++) tick();
    check("len0_start_while_busy_ignored", 64'(busy), 64'd0);
    check("len0_no_strobe", 64'(cap.size()), 64'd0);
    check("len0_single_done", 64'(ndone), 64'd1);

    // Reset mid-burst after the 2nd strobe.
    do_reset();
    for (int i = 1; i <= 4; i++) push_word(DW'(i));
    start = 1'b1; len = 8'd4;
    tick();
    start = 1'b0;
    for (int c = 0; c < 20 && cap.size() < 2; c++) tick();
    check("midrst_two_strobes", 64'(cap.size()), 64'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_outputs", 64'({dout, strobe, busy, done, full, ovf}), 64'd0);
    for (int c = 0; c < 6; c++) tick();
    check("midrst_no_more_strobe", 64'(cap.size()), 64'd2);
    check("midrst_no_done", 64'(ndone), 64'd0);
    start = 1'b1; len = 8'd1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    check("midrst_fifo_empty_stall", 64'({busy, 8'(cap.size())}), 64'({1'b1, 8'd2}));
    do_reset();

    // Randomised bursts against the reference ordering, then a full-length one.
    for (int b = 0; b < 6; b++) run_burst($urandom_range(1, 30), $urandom_range(20, 100));
    run_burst(255, 70);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
